text_source: RTL and testbench

Streams a stored text block out of a synchronous single-port RAM as an ordered byte stream. It is the read-side counterpart of the receive sink, which fills a RAM at addresses 0..end_address. On a start pulse it reads addresses 0..END_ADDRESS in order and presents each byte on a valid/ready output toward the transmit chain. It absorbs the RAM read latency and downstream backpressure without losing or duplicating bytes.

---
 rtl/text_source_pkg.sv | 16 +
 rtl/text_source_if.sv | 22 ++
 rtl/text_source_byte_fifo.sv | 56 +++++
 rtl/text_source.sv | 118 +++++++++++
 tb/tb_text_source.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/text_source_pkg.sv
// Shared definitions for the text source and its companion receive sink:
// FSM state encoding and the default stream/RAM geometry.
package text_source_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 8;
  localparam int END_ADDRESS = 255;

endpackage

// File: rtl/text_source_if.sv
// Valid/ready byte stream from the text source toward the transmit chain.
interface text_source_if #(
  parameter int DATA_W = text_source_pkg::DATA_W
);

  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    output data_out,
    output valid_out,
    input  ready_in
  );

  modport slave (
    input  data_out,
    input  valid_out,
    output ready_in
  );

endinterface

// File: rtl/text_source_byte_fifo.sv
// Small synchronous FIFO with combinational head; push and pop may coincide,
// and a push is still accepted when full if a pop frees a slot that cycle.
module byte_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wrap_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= wrap_inc(rd_ptr_reg);
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/text_source.sv
// Streams RAM[0..END_ADDRESS] out as a valid/ready byte stream, hiding the
// RAM read latency behind a credit-limited FIFO so backpressure never drops bytes.
module text_source #(
  parameter int END_ADDRESS = text_source_pkg::END_ADDRESS,
  parameter int ADDR_W      = text_source_pkg::ADDR_W,
  parameter int DATA_W      = text_source_pkg::DATA_W,
  parameter int RD_LATENCY  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_source,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic              done,
  text_source_if.master     stream
);

  import text_source_pkg::*;

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [RD_LATENCY-1:0] track_reg;
  logic [2:0]        inflight_reg;
  logic [2:0]        inflight_next;
  logic              issue;
  logic              last_issue;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic              drained;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  fifo_count_next;
  logic [DATA_W-1:0] fifo_head;

  // A mark leaving the tracker means mem_q now holds that read's data.
  assign push       = track_reg[RD_LATENCY-1];
  assign pop        = stream.valid_out & stream.ready_in;
  assign credit_ok  = (4'(inflight_reg) + 4'(fifo_count)) < 4'(FIFO_DEPTH);
  assign last_issue = issue && (addr_reg == ADDR_W'(END_ADDRESS));

  assign inflight_next   = inflight_reg + 3'(issue) - 3'(push);
  assign fifo_count_next = fifo_count + CNT_W'(push) - CNT_W'(pop);
  // Looking one edge ahead lets done follow the final transfer immediately.
  assign drained = (inflight_next == 3'd0) && (fifo_count_next == '0);

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_source) state_next = FETCH;
      FETCH:   if (last_issue)   state_next = DRAIN;
      DRAIN:   if (drained)      state_next = FINISH;
      FINISH:                    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    issue = 1'b0;
    case (state_reg)
      FETCH: begin
        busy  = 1'b1;
        issue = credit_ok && !fifo_full;
      end
      DRAIN:   busy = 1'b1;
      FINISH:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_reg     <= '0;
      track_reg    <= '0;
      inflight_reg <= '0;
    end else begin
      track_reg    <= RD_LATENCY'({track_reg, issue});
      inflight_reg <= inflight_next;
      if (state_reg == IDLE && start_source)
        addr_reg <= '0;
      else if (issue && !last_issue)
        addr_reg <= addr_reg + ADDR_W'(1);
    end
  end

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (mem_q),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign mem_address      = addr_reg;
  assign stream.valid_out = !fifo_empty;
  assign stream.data_out  = fifo_empty ? '0 : fifo_head;

endmodule

// File: tb/tb_text_source.sv
// Directed bench: a 256-byte/latency-2 source and a 4-byte/latency-1 source
// sharing start, ready and reset, each fed by a behavioural RAM model.
module tb_text_source;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic ready = 1'b0;

  int n_compared   = 0;
  int n_mismatched = 0;

  logic [7:0] ram_a [256];
  logic [7:0] ram_b [4];
  logic [7:0] mem_address_a;
  logic [1:0] mem_address_b;
  logic [7:0] addr_a_q;
  logic [7:0] mem_q_a;
  logic [7:0] mem_q_b;
  logic       busy_a, done_a, busy_b, done_b;

  text_source_if #(.DATA_W(8)) if_a ();
  text_source_if #(.DATA_W(8)) if_b ();

  assign if_a.ready_in = ready;
  assign if_b.ready_in = ready;

  always #5 clk = ~clk;

  // Registered address and registered output: two cycles of read latency.
  always @(posedge clk) begin
    addr_a_q <= mem_address_a;
    mem_q_a  <= ram_a[addr_a_q];
  end

  always @(posedge clk) begin
    mem_q_b <= ram_b[mem_address_b];
  end

  text_source #(
    .END_ADDRESS (255),
    .ADDR_W      (8),
    .DATA_W      (8),
    .RD_LATENCY  (2)
  ) dut_a (
    .clk          (clk),
    .reset        (reset),
    .start_source (start),
    .mem_address  (mem_address_a),
    .mem_q        (mem_q_a),
    .busy         (busy_a),
    .done         (done_a),
    .stream       (if_a)
  );

  text_source #(
    .END_ADDRESS (3),
    .ADDR_W      (2),
    .DATA_W      (8),
    .RD_LATENCY  (1)
  ) dut_b (
    .clk          (clk),
    .reset        (reset),
    .start_source (start),
    .mem_address  (mem_address_b),
    .mem_q        (mem_q_b),
    .busy         (busy_b),
    .done         (done_b),
    .stream       (if_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: ready always high, 1: ready alternating, 2: ready low for 20
  // cycles after first valid, 3: extra start at byte 100, 4: reset at byte 50.
  task automatic run(input int which, input int mode, input string name);
    int         k = 0;
    int         first = -1;
    int         last = -1;
    int         done_cnt = 0;
    int         done_idx = -1;
    int         rel = -1;
    int         endv;
    int         lat;
    int         nv = 0;
    int         nd = 0;
    int         nb = 0;
    bit         pulsed = 1'b0;
    bit         stalled = 1'b0;
    logic       busy_at_done = 1'b1;
    logic       v, dn, bs;
    logic [7:0] d;
    logic [7:0] held = 8'h00;
    logic [7:0] addr;
    logic [7:0] expb;

    endv  = (which != 0) ? 3 : 255;
    lat   = (which != 0) ? 1 : 2;
    ready = (mode != 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    for (int i = 0; i < 2000; i++) begin
      v    = (which != 0) ? if_b.valid_out : if_a.valid_out;
      d    = (which != 0) ? if_b.data_out  : if_a.data_out;
      dn   = (which != 0) ? done_b : done_a;
      bs   = (which != 0) ? busy_b : busy_a;
      addr = (which != 0) ? {6'b0, mem_address_b} : mem_address_a;

      if (i == 0) begin
        check($sformatf("%s.addr0", name), 32'(addr), 32'd0);
        check($sformatf("%s.busy0", name), 32'(bs), 32'd1);
      end
      if (dn) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_idx     = i;
          busy_at_done = bs;
        end
      end
      if (v && first < 0) first = i;

      case (mode)
        1:       ready = (i % 2 == 0);
        2: begin
          ready = (first >= 0 && i >= first + 20);
          if (ready && rel < 0) rel = i;
        end
        default: ready = 1'b1;
      endcase

      if (mode == 2 && rel >= 0) begin
        if (i == rel)     check($sformatf("%s.stall_addr", name), 32'(addr), 32'd4);
        if (i == rel + 1) check($sformatf("%s.resume_wait", name), 32'(addr), 32'd4);
        if (i == rel + 2) check($sformatf("%s.resume_addr", name), 32'(addr), 32'd5);
      end

      if (stalled) begin
        check($sformatf("%s.hold_valid", name), 32'(v), 32'd1);
        check($sformatf("%s.hold_data", name), 32'(d), 32'(held));
      end
      stalled = 1'b0;
      if (v) begin
        if (ready) begin
          expb = (which != 0) ? 8'(8'hA0 + k) : 8'(k);
          check($sformatf("%s.byte%0d", name, k), 32'(d), 32'(expb));
          if (k == endv) last = i;
          k++;
        end else begin
          stalled = 1'b1;
          held    = d;
        end
      end

      start = (mode == 3 && k == 100 && !pulsed);
      if (start) pulsed = 1'b1;
      if (mode == 4 && k == 50) break;
      if (done_cnt > 0 && i >= done_idx + 4) break;
      @(negedge clk);
    end

    if (mode == 4) begin
      ready = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int j = 0; j < 30; j++) begin
        @(negedge clk);
        if (if_a.valid_out) nv++;
        if (done_a) nd++;
        if (busy_a) nb++;
      end
      check($sformatf("%s.quiet_valid", name), 32'(nv), 32'd0);
      check($sformatf("%s.quiet_done", name), 32'(nd), 32'd0);
      check($sformatf("%s.quiet_busy", name), 32'(nb), 32'd0);
      $display("run %s: %0d bytes before reset, valid=%0d done=%0d busy=%0d cycles after",
               name, k, nv, nd, nb);
      return;
    end

    check($sformatf("%s.count", name), 32'(k), 32'(endv + 1));
    check($sformatf("%s.first_valid", name), 32'(first), 32'(lat + 1));
    check($sformatf("%s.done_count", name), 32'(done_cnt), 32'd1);
    check($sformatf("%s.done_cycle", name), 32'(done_idx), 32'(last + 1));
    check($sformatf("%s.busy_at_done", name), 32'(busy_at_done), 32'd0);
    if (mode == 0)
      check($sformatf("%s.span", name), 32'(last - first), 32'(endv));
    $display("run %s: bytes=%0d first_valid=%0d last=%0d done=%0d dones=%0d",
             name, k, first, last, done_idx, done_cnt);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) ram_a[k] = 8'(k);
    for (int k = 0; k < 4; k++)   ram_b[k] = 8'(8'hA0 + k);

    repeat (3) @(negedge clk);
    check("reset.valid", 32'(if_a.valid_out), 32'd0);
    check("reset.data", 32'(if_a.data_out), 32'd0);
    check("reset.busy", 32'(busy_a), 32'd0);
    check("reset.done", 32'(done_a), 32'd0);
    check("reset.addr", 32'(mem_address_a), 32'd0);
    check("reset.valid_b", 32'(if_b.valid_out), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run(0, 0, "full_rate");
    run(0, 1, "alternate");
    run(0, 2, "stall20");
    run(0, 3, "restart_ignored");
    run(0, 4, "reset_mid");
    run(0, 0, "after_reset");
    run(1, 0, "short_lat1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
